// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment scan controller:
// segment patterns (bit 6 = a ... bit 0 = g, active-high) and the scan state type.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;

    // ON: current digit lit for its dwell; GAP: all digits dark between digits.
    typedef enum logic {
        ON  = 1'b0,
        GAP = 1'b1
    } scan_state_t;

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Data/display bundle for seg7_scan_ctrl.
// Handshake: there is no valid/ready pair here. load is a single-cycle strobe that
// the controller always accepts on the rising edge where it is high; bcd_in is only
// meaningful in that cycle. The display side (seg, an) has no backpressure.
interface seg7_scan_ctrl_if #(
    parameter int NUM_DIGITS = 4
);
    logic                      en;
    logic                      load;
    logic [4*NUM_DIGITS-1:0]   bcd_in;
    logic [6:0]                seg;
    logic [NUM_DIGITS-1:0]     an;
    logic                      frame_done;
    logic                      pending;

    // Producer of BCD data / consumer of the pin drive.
    modport master (
        output en, load, bcd_in,
        input  seg, an, frame_done, pending
    );

    // The scan controller itself.
    modport slave (
        input  en, load, bcd_in,
        output seg, an, frame_done, pending
    );
endinterface

// File: rtl/seg7_decode.sv
// BCD-to-7-segment decoder, purely combinational. Codes 10-15 render blank.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] pattern
);

    // Map one BCD code onto its segment pattern.
    always_comb begin
        pattern = SEG_BLANK;
        case (code)
            4'd0:    pattern = SEG_0;
            4'd1:    pattern = SEG_1;
            4'd2:    pattern = SEG_2;
            4'd3:    pattern = SEG_3;
            4'd4:    pattern = SEG_4;
            4'd5:    pattern = SEG_5;
            4'd6:    pattern = SEG_6;
            4'd7:    pattern = SEG_7;
            4'd8:    pattern = SEG_8;
            4'd9:    pattern = SEG_9;
            default: pattern = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for a common-cathode multi-digit 7-segment display.
// Each digit is lit for REFRESH_DIV cycles, followed by DEAD_CYCLES dark cycles.
// New data is staged in a shadow register and moved to the displayed register only
// when the scan wraps from the last digit back to digit 0, so a frame never mixes data.
// Optional feature macro: LEADING_ZERO_BLANK_EN (blank leading zero digits above digit 0).
// Outputs are registered from the pre-edge scan position, so the pins lag the
// internal state by one cycle; the scan state is exposed on scan_state.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int DEAD_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    seg7_scan_ctrl_if.slave  bus,
    output scan_state_t      scan_state
);

    localparam int CNT_MAX = (REFRESH_DIV > DEAD_CYCLES) ? REFRESH_DIV : DEAD_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int IDX_W   = $clog2(NUM_DIGITS);
    localparam int DATA_W  = 4 * NUM_DIGITS;

    localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((DEAD_CYCLES > 0) ? DEAD_CYCLES - 1 : 0);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    scan_state_t             state;
    logic [IDX_W-1:0]        idx;
    logic [CNT_W-1:0]        div_cnt;
    logic [DATA_W-1:0]       active;
    logic [DATA_W-1:0]       shadow;
    logic                    pending_q;
    logic [6:0]              seg_q;
    logic [NUM_DIGITS-1:0]   an_q;
    logic                    frame_done_q;

    logic                    dwell_end;
    logic                    advance;
    logic                    wrap;
    logic [IDX_W-1:0]        idx_next;
    logic [3:0]              digit_code;
    logic [6:0]              digit_pattern;
    logic [6:0]              lit_pattern;
    logic [NUM_DIGITS-1:0]   an_onehot;
    logic                    upper_zero;

    // Dwell/advance/wrap decisions for the current scan position.
    always_comb begin
        dwell_end = (state == ON) ? (div_cnt == ON_LAST) : (div_cnt == GAP_LAST);
        // With no dead time the ON dwell end advances the digit directly.
        advance   = bus.en && dwell_end && ((state == GAP) || (DEAD_CYCLES == 0));
        wrap      = advance && (idx == IDX_LAST);
        idx_next  = (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end

    // Select the current digit from active data, build its one-hot enable and
    // the leading-zero condition (every digit from idx upward is zero).
    always_comb begin
        digit_code = 4'd0;
        an_onehot  = '0;
        upper_zero = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                digit_code   = active[4*i +: 4];
                an_onehot[i] = 1'b1;
                upper_zero   = (i > 0) && ((active >> (4*i)) == '0);
            end
        end
    end

    seg7_decode u_decode (
        .code    (digit_code),
        .pattern (digit_pattern)
    );

    // Pattern actually driven while the digit is lit.
    always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
        lit_pattern = upper_zero ? SEG_BLANK : digit_pattern;
`else
        lit_pattern = digit_pattern;
`endif
    end

    // Scan FSM: dwell counting, digit advance and registered pin outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ON;
            idx          <= '0;
            div_cnt      <= '0;
            seg_q        <= SEG_BLANK;
            an_q         <= '0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= wrap;
            if (bus.en && (state == ON)) begin
                an_q  <= an_onehot;
                seg_q <= lit_pattern;
            end else begin
                an_q  <= '0;
                seg_q <= SEG_BLANK;
            end
            if (bus.en) begin
                case (state)
                    ON: begin
                        if (dwell_end) begin
                            div_cnt <= '0;
                            if (DEAD_CYCLES == 0) begin
                                idx <= idx_next;
                            end else begin
                                state <= GAP;
                            end
                        end else begin
                            div_cnt <= div_cnt + 1'b1;
                        end
                    end
                    GAP: begin
                        if (dwell_end) begin
                            div_cnt <= '0;
                            idx     <= idx_next;
                            state   <= ON;
                        end else begin
                            div_cnt <= div_cnt + 1'b1;
                        end
                    end
                    default: begin
                        state   <= ON;
                        div_cnt <= '0;
                    end
                endcase
            end
        end
    end

    // Shadow/active data: loads stage into shadow, wraps publish shadow; a load on
    // the wrap edge goes straight to active so nothing is left pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            active    <= '0;
            shadow    <= '0;
            pending_q <= 1'b0;
        end else if (bus.load) begin
            if (wrap) begin
                active    <= bus.bcd_in;
                pending_q <= 1'b0;
            end else begin
                shadow    <= bus.bcd_in;
                pending_q <= 1'b1;
            end
        end else if (wrap && pending_q) begin
            active    <= shadow;
            pending_q <= 1'b0;
        end
    end

    assign bus.seg        = seg_q;
    assign bus.an         = an_q;
    assign bus.frame_done = frame_done_q;
    assign bus.pending    = pending_q;
    assign scan_state     = state;

endmodule
